// File: rtl/uart_rx_stream.sv
// UART receiver (idle high, 8N1, LSB first) with a 1-deep valid/ready holding register.
// Optional even/odd parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_stream #(
    parameter int BAUD_DIV    = 1302,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       ovf_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       busy_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] CNT_HALF = 16'(BAUD_DIV / 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        complete;
    logic        ferr;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
        ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a high here was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BREAK: begin
                // Hold here while the line stays low so a break cannot look like a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake: data_o is taken when valid_o && ready_i on the same rising edge;
    // data_o holds steady while valid_o is high and ready_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o       <= 8'h00;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            ovf_o        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= ferr;
            ovf_o       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= complete & (par_q ^ (^shift_q) ^ PARITY_ODD);
`endif
            if (complete) begin
                if (valid_o && !ready_i) begin
                    ovf_o <= 1'b1;
                end else begin
                    data_o  <= shift_q;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at BAUD_DIV=16: basic receive, glitch, framing error,
// overrun, simultaneous accept/complete and reset mid-frame.
module tb_uart_rx_stream;

    localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int COMPLETE_OFS = 155 + BAUD;
`else
    localparam int COMPLETE_OFS = 155;
`endif

    logic       clk_i = 1'b0;
    logic       arst_n_i;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       ovf_o;
    logic       busy_o;
    logic [2:0] state_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    uart_rx_stream #(
        .BAUD_DIV    (BAUD),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int  acc_cnt   = 0;
    int  ferr_cnt  = 0;
    int  ovf_cnt   = 0;
    int  extra_cnt = 0;
    bit  valid_low_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: consumer side, sampled mid-cycle
    always @(negedge clk_i) begin
        if (arst_n_i) begin
            if (frame_err_o) ferr_cnt++;
            if (ovf_o) ovf_cnt++;
            if (!valid_o) valid_low_seen = 1'b1;
            if (valid_o && ready_i) begin
                acc_cnt++;
                if (exp_q.size() > 0) check_eq("rx_byte", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
                else extra_cnt++;
            end
        end
    end

    // driver tasks: every call starts and ends 1 time unit after a rising edge
    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (BAUD) @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
    endtask

    int acc0, ferr0, ovf0;
    logic [7:0] part;

    initial begin
        arst_n_i = 1'b0;
        rx_i     = 1'b1;
        ready_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_data",  {24'h0, data_o}, 32'h0);
        check_eq("rst_valid", {31'h0, valid_o}, 32'h0);
        check_eq("rst_ferr",  {31'h0, frame_err_o}, 32'h0);
        check_eq("rst_ovf",   {31'h0, ovf_o}, 32'h0);
        check_eq("rst_busy",  {31'h0, busy_o}, 32'h0);
        check_eq("rst_state", {29'h0, state_o}, 32'd0);
        arst_n_i = 1'b1;
        idle(5);

        // basic receive
        ready_i = 1'b1;
        acc0 = acc_cnt; ferr0 = ferr_cnt; ovf0 = ovf_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(8);
        check_eq("basic_accepts", acc_cnt - acc0, 1);
        check_eq("basic_ferr", ferr_cnt - ferr0, 0);
        check_eq("basic_ovf", ovf_cnt - ovf0, 0);
        check_eq("basic_busy", {31'h0, busy_o}, 32'h0);
        check_eq("basic_valid_low", {31'h0, valid_o}, 32'h0);

        // start-bit glitch
        acc0 = acc_cnt; ferr0 = ferr_cnt;
        rx_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        idle(20);
        check_eq("glitch_state", {29'h0, state_o}, 32'd0);
        check_eq("glitch_accepts", acc_cnt - acc0, 0);
        check_eq("glitch_ferr", ferr_cnt - ferr0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(8);
        check_eq("glitch_next_accepts", acc_cnt - acc0, 1);

        // framing error followed by a held-low line
        acc0 = acc_cnt; ferr0 = ferr_cnt;
        send_frame(8'hFF, 1'b0);
        rx_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        check_eq("ferr_pulses", ferr_cnt - ferr0, 1);
        check_eq("ferr_break_state", {29'h0, state_o}, 32'd5);
        check_eq("ferr_no_byte", acc_cnt - acc0, 0);
        idle(16);
        check_eq("ferr_idle_state", {29'h0, state_o}, 32'd0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        idle(8);
        check_eq("ferr_next_accepts", acc_cnt - acc0, 1);
        check_eq("ferr_total_pulses", ferr_cnt - ferr0, 1);

        // backpressure and overrun
        ready_i = 1'b0;
        acc0 = acc_cnt; ovf0 = ovf_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        idle(8);
        check_eq("ovf_data_held", {24'h0, data_o}, 32'h11);
        check_eq("ovf_valid_held", {31'h0, valid_o}, 32'h1);
        check_eq("ovf_pulses", ovf_cnt - ovf0, 2);
        check_eq("ovf_no_accept", acc_cnt - acc0, 0);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check_eq("ovf_valid_drop", {31'h0, valid_o}, 32'h0);
        check_eq("ovf_accepts", acc_cnt - acc0, 1);

        // simultaneous accept and completion
        exp_q.push_back(8'h44);
        send_frame(8'h44, 1'b1);
        idle(4);
        check_eq("sim_hold_data", {24'h0, data_o}, 32'h44);
        exp_q.push_back(8'h55);
        ovf0 = ovf_cnt;
        valid_low_seen = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (COMPLETE_OFS) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                ready_i = 1'b0;
            end
        join
        idle(4);
        check_eq("sim_data", {24'h0, data_o}, 32'h55);
        check_eq("sim_valid", {31'h0, valid_o}, 32'h1);
        check_eq("sim_valid_never_low", {31'h0, valid_low_seen}, 32'h0);
        check_eq("sim_ovf", ovf_cnt - ovf0, 0);
        check_eq("sim_pending", exp_q.size(), 1);

        // reset in the middle of DATA bit 4; the held 0x55 is lost too
        exp_q.delete();
        acc0 = acc_cnt;
        part = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        rx_i = part[4];
        repeat (8) @(posedge clk_i);
        #1;
        check_eq("mid_state_data", {29'h0, state_o}, 32'd2);
        #2;
        arst_n_i = 1'b0;
        #1;
        check_eq("mid_rst_data",  {24'h0, data_o}, 32'h0);
        check_eq("mid_rst_valid", {31'h0, valid_o}, 32'h0);
        check_eq("mid_rst_busy",  {31'h0, busy_o}, 32'h0);
        check_eq("mid_rst_state", {29'h0, state_o}, 32'd0);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        ready_i  = 1'b1;
        idle(32);
        check_eq("mid_no_7e", acc_cnt - acc0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(8);
        check_eq("mid_next_accepts", acc_cnt - acc0, 1);
        check_eq("final_pending", exp_q.size(), 0);
        check_eq("final_extra", extra_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
